// File: rtl/led_bounce_monitor_pkg.sv
// Shared types and helpers for the LED bounce monitor: bus widths, FSM states
// and the one-hot decoder used to turn the LED bus into a position.
package led_bounce_pkg;

    localparam int LED_W = 8;
    localparam int POS_W = 3;
    localparam int CNT_W = 26;
    localparam int CM_W  = 25;

    typedef enum logic [1:0] {IDLE, SYNC, TRACK} mon_state_t;

    typedef struct packed {
        logic             valid;
        logic [POS_W-1:0] idx;
    } onehot_t;

    function automatic onehot_t onehot_idx(input logic [LED_W-1:0] v);
        onehot_t r;
        r.valid = ($countones(v) == 1);
        r.idx   = '0;
        for (int i = 0; i < LED_W; i++) begin
            if (v[i]) r.idx = POS_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/led_bounce_monitor_if.sv
// Signal bundle between the LED bus source (master) and the bounce monitor (slave).
interface led_bounce_monitor_if import led_bounce_pkg::*; #(
    parameter int BCNT_W = 16
);
    logic [CM_W-1:0]   count_max;
    logic [LED_W-1:0]  led_in;
    logic              locked;
    logic [POS_W-1:0]  pos;
    logic              dir;
    logic              err_onehot;
    logic              err_step;
    logic              err_timing;
    logic              err_sticky;
    logic [BCNT_W-1:0] bounce_count;

    modport master (
        output count_max, led_in,
        input  locked, pos, dir, err_onehot, err_step, err_timing, err_sticky, bounce_count
    );

    modport slave (
        input  count_max, led_in,
        output locked, pos, dir, err_onehot, err_step, err_timing, err_sticky, bounce_count
    );
endinterface

// File: rtl/led_bounce_monitor_dwell_timer.sv
// Saturating dwell counter with a tolerance window around count_max+1.
// early/late grade a finished dwell; stall flags one cycle past the window.
module dwell_timer import led_bounce_pkg::*; #(
    parameter int TOL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_clear,
    input  logic [CM_W-1:0] i_count_max,
    output logic            o_early,
    output logic            o_late,
    output logic            o_stall
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_dwell;
    logic [CNT_W-1:0] w_tol;
    logic [CNT_W-1:0] w_lo;
    logic [CNT_W-1:0] w_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // lo never drops below 1 so a tiny count_max still has a sane window
    assign w_dwell = {1'b0, i_count_max} + CNT_W'(1);
    assign w_tol   = CNT_W'(TOL);
    assign w_lo    = (w_dwell > w_tol) ? (w_dwell - w_tol) : CNT_W'(1);
    assign w_hi    = w_dwell + w_tol;

    assign o_early = (r_cnt < w_lo);
    assign o_late  = (r_cnt > w_hi);
    assign o_stall = (r_cnt == (w_hi + CNT_W'(1)));

endmodule

// File: rtl/led_bounce_monitor.sv
// Passive receiver for the bouncing one-hot LED bus: recovers position and
// direction, counts end reversals and flags one-hot, step and dwell errors.
module led_bounce_monitor import led_bounce_pkg::*; #(
    parameter int TOL    = 1,
    parameter int BCNT_W = 16
) (
    input  logic             CLK_50M,
    input  logic             reset,
    led_bounce_monitor_if.slave bus
);

    mon_state_t        r_state;
    logic [LED_W-1:0]  r_ledQ;
    logic [LED_W-1:0]  r_ledP;
    logic [POS_W-1:0]  r_pos;
    logic              r_dir;
    logic              r_locked;
    logic              r_errOnehot;
    logic              r_errStep;
    logic              r_errTiming;
    logic              r_errSticky;
    logic [BCNT_W-1:0] r_bounce;

    onehot_t           w_oh;
    logic              w_change;
    logic              w_early;
    logic              w_late;
    logic              w_stall;
    logic [POS_W:0]    w_posExt;
    logic [POS_W:0]    w_idxExt;
    logic              w_adjUp;
    logic              w_adjDown;
    logic [POS_W-1:0]  w_nextPos;
    logic              w_nextDir;
    logic              w_reflect;

    assign w_oh     = onehot_idx(r_ledQ);
    assign w_change = (r_ledQ != r_ledP);

    dwell_timer #(.TOL(TOL)) u_dwell (
        .clk         (CLK_50M),
        .reset       (reset),
        .i_clear     (w_change),
        .i_count_max (bus.count_max),
        .o_early     (w_early),
        .o_late      (w_late),
        .o_stall     (w_stall)
    );

    // Widened compare so 7 and 0 are never mistaken for neighbours
    assign w_posExt  = {1'b0, r_pos};
    assign w_idxExt  = {1'b0, w_oh.idx};
    assign w_adjUp   = (w_idxExt == w_posExt + (POS_W+1)'(1));
    assign w_adjDown = (w_posExt == w_idxExt + (POS_W+1)'(1));

    always_comb begin
        w_nextPos = r_pos;
        w_nextDir = r_dir;
        w_reflect = 1'b0;
        if (r_dir && r_pos == POS_W'(LED_W-1)) begin
            w_nextPos = POS_W'(LED_W-2);
            w_nextDir = 1'b0;
            w_reflect = 1'b1;
        end else if (!r_dir && r_pos == '0) begin
            w_nextPos = POS_W'(1);
            w_nextDir = 1'b1;
            w_reflect = 1'b1;
        end else if (r_dir) begin
            w_nextPos = r_pos + POS_W'(1);
        end else begin
            w_nextPos = r_pos - POS_W'(1);
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ledQ      <= '0;
            r_ledP      <= '0;
            r_pos       <= '0;
            r_dir       <= 1'b1;
            r_locked    <= 1'b0;
            r_errOnehot <= 1'b0;
            r_errStep   <= 1'b0;
            r_errTiming <= 1'b0;
            r_errSticky <= 1'b0;
            r_bounce    <= '0;
        end else begin
            r_ledQ      <= bus.led_in;
            r_ledP      <= r_ledQ;
            r_errOnehot <= 1'b0;
            r_errStep   <= 1'b0;
            r_errTiming <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_oh.valid) begin
                        r_state <= SYNC;
                        r_pos   <= w_oh.idx;
                    end else if (w_change) begin
                        r_errOnehot <= 1'b1;
                        r_errSticky <= 1'b1;
                    end
                end
                // Phase is unknown here, so the first legal step is not timed
                SYNC: begin
                    if (w_change) begin
                        if (!w_oh.valid) begin
                            r_errOnehot <= 1'b1;
                            r_errSticky <= 1'b1;
                            r_state     <= IDLE;
                        end else if (w_adjUp || w_adjDown) begin
                            r_pos    <= w_oh.idx;
                            r_dir    <= w_adjUp;
                            r_locked <= 1'b1;
                            r_state  <= TRACK;
                        end else begin
                            r_errStep   <= 1'b1;
                            r_errSticky <= 1'b1;
                            r_pos       <= w_oh.idx;
                        end
                    end
                end
                TRACK: begin
                    if (w_change) begin
                        if (!w_oh.valid) begin
                            r_errOnehot <= 1'b1;
                            r_errSticky <= 1'b1;
                            r_locked    <= 1'b0;
                            r_state     <= IDLE;
                        end else if (w_oh.idx == w_nextPos) begin
                            r_pos <= w_oh.idx;
                            r_dir <= w_nextDir;
                            if (w_reflect) r_bounce <= r_bounce + BCNT_W'(1);
                            if (w_early || w_late) begin
                                r_errTiming <= 1'b1;
                                r_errSticky <= 1'b1;
                            end
                        end else begin
                            r_errStep   <= 1'b1;
                            r_errSticky <= 1'b1;
                            r_pos       <= w_oh.idx;
                            r_locked    <= 1'b0;
                            r_state     <= SYNC;
                        end
                    end else if (w_stall) begin
                        r_errTiming <= 1'b1;
                        r_errSticky <= 1'b1;
                        r_locked    <= 1'b0;
                        r_state     <= SYNC;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.locked       = r_locked;
    assign bus.pos          = r_pos;
    assign bus.dir          = r_dir;
    assign bus.err_onehot   = r_errOnehot;
    assign bus.err_step     = r_errStep;
    assign bus.err_timing   = r_errTiming;
    assign bus.err_sticky   = r_errSticky;
    assign bus.bounce_count = r_bounce;

endmodule
